// File: rtl/hex_display_bank_if.sv
// Bus bundle for hex_display_bank: write port, scroll enable and display outputs.
// BLINK exists only when HEX_DISPLAY_BANK_BLINK_EN is defined.
interface hex_display_bank_if #(
    parameter int N_DISP = 6,
    parameter int AW     = 4
);
    logic                  WR_EN;
    logic [AW-1:0]         ADDR;
    logic [6:0]            DATA;
    logic                  MODE;
    logic                  SCROLL_EN;
    logic [N_DISP*7-1:0]   HEX;
    logic                  ADDR_ERR;
`ifdef HEX_DISPLAY_BANK_BLINK_EN
    logic [N_DISP-1:0]     BLINK;
`endif

    modport master (
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        output BLINK,
`endif
        output WR_EN, ADDR, DATA, MODE, SCROLL_EN,
        input  HEX, ADDR_ERR
    );

    modport slave (
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        input  BLINK,
`endif
        input  WR_EN, ADDR, DATA, MODE, SCROLL_EN,
        output HEX, ADDR_ERR
    );
endinterface

// File: rtl/hex_display_bank.sv
// Bank of N_DISP seven-segment registers with raw/hex-decode writes and a timed rotate.
// Optional blink output stage enabled by defining HEX_DISPLAY_BANK_BLINK_EN.
module hex_display_bank #(
    parameter int N_DISP    = 6,
    parameter int AW        = 4,
    parameter int TICK_DIV  = 25000000
`ifdef HEX_DISPLAY_BANK_BLINK_EN
   ,parameter int BLINK_DIV = 12500000
`endif
) (
    input  logic             CLOCK,
    input  logic             RESETn,
    hex_display_bank_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Active-low segment patterns, bit 0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [N_DISP-1:0][6:0] disp_q, disp_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   addr_err_q, addr_err_d;
    logic                   step_s;
    logic                   addr_ok_s;
    logic [6:0]             wdata_s;

    // Step, address range check and write data selection.
    always_comb begin
        step_s    = bus.SCROLL_EN && (presc_q == PW'(TICK_DIV - 1));
        addr_ok_s = ({1'b0, bus.ADDR} < (AW + 1)'(N_DISP));
        if (bus.MODE) begin
            wdata_s = hex_to_seg(bus.DATA[3:0]);
        end else begin
            wdata_s = bus.DATA;
        end
    end

    // Next state: prescaler, rotate, then the write overrides its target.
    always_comb begin
        disp_d     = disp_q;
        presc_d    = presc_q;
        addr_err_d = 1'b0;
        if (!bus.SCROLL_EN) begin
            presc_d = '0;
        end else if (step_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (step_s) begin
            for (int d = 0; d < N_DISP; d++) begin
                disp_d[d] = disp_q[(d + N_DISP - 1) % N_DISP];
            end
        end else begin
            disp_d = disp_q;
        end
        for (int d = 0; d < N_DISP; d++) begin
            if (bus.WR_EN && addr_ok_s && (bus.ADDR == AW'(d))) begin
                disp_d[d] = wdata_s;
            end else begin
                disp_d[d] = disp_d[d];
            end
        end
        if (bus.WR_EN && !addr_ok_s) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = 1'b0;
        end
    end

    // Display registers, prescaler and error pulse with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            disp_q     <= {N_DISP{7'h7F}};
            presc_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.ADDR_ERR = addr_err_q;

`ifdef HEX_DISPLAY_BANK_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_on_q, blink_on_d;
    logic [N_DISP-1:0][6:0] hex_q, hex_d;

    // Blink half-period counter and masked output stage.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end else begin
            blink_on_d  = blink_on_q;
        end
        for (int d = 0; d < N_DISP; d++) begin
            if (bus.BLINK[d] && !blink_on_q) begin
                hex_d[d] = 7'h7F;
            end else begin
                hex_d[d] = disp_q[d];
            end
        end
    end

    // Blink state and registered display outputs.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            hex_q       <= {N_DISP{7'h7F}};
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            hex_q       <= hex_d;
        end
    end

    assign bus.HEX = hex_q;
`else
    assign bus.HEX = disp_q;
`endif
endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank (N_DISP=6, TICK_DIV=4): a behavioural model
// pushes the expected HEX/ADDR_ERR per driven cycle; they are popped after the edge.
module tb_hex_display_bank;
    localparam int N_DISP   = 6;
    localparam int AW       = 4;
    localparam int TICK_DIV = 4;

    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [N_DISP*7-1:0] hex;
        logic                err;
    } exp_t;

    logic CLOCK;
    logic RESETn;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    logic [6:0] m_disp [N_DISP];
    int   m_presc;
    logic [N_DISP*7-1:0] saved_hex;

    localparam logic [41:0] ORIG = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    hex_display_bank_if #(.N_DISP(N_DISP), .AW(AW)) bus ();

    hex_display_bank #(
        .N_DISP   (N_DISP),
        .AW       (AW),
        .TICK_DIV (TICK_DIV)
`ifdef HEX_DISPLAY_BANK_BLINK_EN
       ,.BLINK_DIV(3)
`endif
    ) dut (
        .CLOCK  (CLOCK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic cycle(input logic rstn, input logic wr, input logic [AW-1:0] addr,
                         input logic [6:0] data, input logic mode, input logic scroll);
        exp_t e;
        exp_t got;
        logic step;
        logic [6:0] tmp;
        @(negedge CLOCK);
        RESETn        = rstn;
        bus.WR_EN     = wr;
        bus.ADDR      = addr;
        bus.DATA      = data;
        bus.MODE      = mode;
        bus.SCROLL_EN = scroll;
        if (!rstn) begin
            for (int d = 0; d < N_DISP; d++) m_disp[d] = 7'h7F;
            m_presc = 0;
            e.err   = 1'b0;
        end else begin
            step = scroll && (m_presc == TICK_DIV - 1);
            if (!scroll) m_presc = 0;
            else if (step) m_presc = 0;
            else m_presc = m_presc + 1;
            if (step) begin
                tmp = m_disp[N_DISP-1];
                for (int d = N_DISP - 1; d > 0; d--) m_disp[d] = m_disp[d-1];
                m_disp[0] = tmp;
            end
            if (wr && (int'(addr) < N_DISP)) begin
                m_disp[addr] = mode ? DEC[data[3:0]] : data;
            end
            e.err = wr && (int'(addr) >= N_DISP);
        end
        for (int d = 0; d < N_DISP; d++) e.hex[d*7 +: 7] = m_disp[d];
        sb_q.push_back(e);
        @(posedge CLOCK);
        #1;
        got = sb_q.pop_front();
        check_val("sb_hex", 64'(bus.HEX), 64'(got.hex));
        check_val("sb_addr_err", 64'(bus.ADDR_ERR), 64'(got.err));
    endtask

    task automatic idle(input logic scroll);
        cycle(1'b1, 1'b0, 4'd0, 7'h00, 1'b0, scroll);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_presc = 0;
        for (int d = 0; d < N_DISP; d++) m_disp[d] = 7'h7F;
        RESETn        = 1'b0;
        bus.WR_EN     = 1'b0;
        bus.ADDR      = '0;
        bus.DATA      = '0;
        bus.MODE      = 1'b0;
        bus.SCROLL_EN = 1'b0;
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        bus.BLINK     = '0;
`endif

        // Reset wins over a concurrent write; the write lands once released.
        repeat (2) cycle(1'b0, 1'b1, 4'd0, 7'h00, 1'b0, 1'b0);
        check_val("reset_hex", 64'(bus.HEX), 64'({N_DISP{7'h7F}}));
        check_val("reset_err", 64'(bus.ADDR_ERR), 64'd0);
        cycle(1'b1, 1'b1, 4'd0, 7'h00, 1'b0, 1'b0);
        check_val("post_reset_write", 64'(bus.HEX[6:0]), 64'h00);

        for (int i = 0; i < N_DISP; i++) cycle(1'b1, 1'b1, 4'(i), 7'(i + 1), 1'b1, 1'b0);
        check_val("decode_1to6", 64'(bus.HEX),
                  64'({7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}));
        cycle(1'b1, 1'b1, 4'd3, 7'h55, 1'b0, 1'b0);
        check_val("raw_addr3", 64'(bus.HEX[27:21]), 64'h55);

        saved_hex = bus.HEX;
        cycle(1'b1, 1'b1, 4'd6, 7'h11, 1'b0, 1'b0);
        check_val("bad6_err", 64'(bus.ADDR_ERR), 64'd1);
        check_val("bad6_hex", 64'(bus.HEX), 64'(saved_hex));
        idle(1'b0);
        check_val("bad6_err_clr", 64'(bus.ADDR_ERR), 64'd0);
        cycle(1'b1, 1'b1, 4'd15, 7'h22, 1'b1, 1'b0);
        check_val("bad15_err_a", 64'(bus.ADDR_ERR), 64'd1);
        cycle(1'b1, 1'b1, 4'd15, 7'h22, 1'b1, 1'b0);
        check_val("bad15_err_b", 64'(bus.ADDR_ERR), 64'd1);
        idle(1'b0);
        check_val("bad15_err_clr", 64'(bus.ADDR_ERR), 64'd0);

        // Preload digits 0..5; upper DATA bits are junk and must be ignored.
        for (int i = 0; i < N_DISP; i++) cycle(1'b1, 1'b1, 4'(i), {3'b101, 4'(i)}, 1'b1, 1'b0);
        check_val("preload", 64'(bus.HEX), 64'(ORIG));

        repeat (TICK_DIV) idle(1'b1);
        check_val("step1_d0", 64'(bus.HEX[6:0]), 64'h12);
        check_val("step1_d1", 64'(bus.HEX[13:7]), 64'h40);
        repeat (5 * TICK_DIV) idle(1'b1);
        check_val("six_steps", 64'(bus.HEX), 64'(ORIG));
        repeat (10) idle(1'b0);
        check_val("scroll_off", 64'(bus.HEX), 64'(ORIG));

        repeat (TICK_DIV - 1) idle(1'b1);
        cycle(1'b1, 1'b1, 4'd2, 7'h3F, 1'b0, 1'b1);
        check_val("collision", 64'(bus.HEX),
                  64'({7'h19, 7'h30, 7'h24, 7'h3F, 7'h40, 7'h12}));

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom), 7'($urandom),
                  1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
